type_dispatcher: RTL and testbench

TYPE_DISPATCHER -- requirements
Module: type_dispatcher

---
 rtl/type_dispatcher.sv | 128 ++++++++++++
 tb/tb_type_dispatcher.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/type_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | type_dispatcher: routes 45-bit stateType words into per-lane FIFOs    |
// | by type_in[44:42]; show-ahead lane outputs. Revision: 1.0             |
// +------------------------------------------------------------------------+
module type_dispatcher #(
  parameter int numExtraction   = 8,
  parameter int widthExtraction = 3,
  parameter int fifoDepth       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [44:0] type_in,
  input  logic        type_in_valid,
  output logic        type_in_ready,
  output logic        stateType_valid_0,
  output logic        stateType_valid_1,
  output logic        stateType_valid_2,
  output logic        stateType_valid_3,
  output logic        stateType_valid_4,
  output logic        stateType_valid_5,
  output logic        stateType_valid_6,
  output logic        stateType_valid_7,
  output logic [44:0] stateType_0,
  output logic [44:0] stateType_1,
  output logic [44:0] stateType_2,
  output logic [44:0] stateType_3,
  output logic [44:0] stateType_4,
  output logic [44:0] stateType_5,
  output logic [44:0] stateType_6,
  output logic [44:0] stateType_7,
  input  logic        stateType_ready_0,
  input  logic        stateType_ready_1,
  input  logic        stateType_ready_2,
  input  logic        stateType_ready_3,
  input  logic        stateType_ready_4,
  input  logic        stateType_ready_5,
  input  logic        stateType_ready_6,
  input  logic        stateType_ready_7,
  output logic [15:0] dispatch_count
);

  localparam int c_ptrWidth = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int c_cntWidth = $clog2(fifoDepth + 1);

  logic [widthExtraction-1:0] w_sel;
  logic                       w_push;
  logic [numExtraction-1:0]   w_popReady;
  logic [numExtraction-1:0]   w_valid;
  logic [44:0]                w_head  [numExtraction];
  logic [c_cntWidth-1:0]      w_count [numExtraction];
  logic [15:0]                r_dispatchCount;

  assign w_sel         = type_in[44 -: widthExtraction];
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign type_in_ready = (w_count[w_sel] < c_cntWidth'(fifoDepth));
  assign w_push        = type_in_valid && type_in_ready;
  assign w_popReady    = {stateType_ready_7, stateType_ready_6, stateType_ready_5, stateType_ready_4,
                          stateType_ready_3, stateType_ready_2, stateType_ready_1, stateType_ready_0};

  generate
    for (genvar k = 0; k < numExtraction; k++) begin : g_lane
      logic [44:0]           r_mem [fifoDepth];
      logic [c_ptrWidth-1:0] r_wrPtr;
      logic [c_ptrWidth-1:0] r_rdPtr;
      logic [c_cntWidth-1:0] r_count;
      logic                  w_lanePush;
      logic                  w_lanePop;

      assign w_lanePush = w_push && (w_sel == widthExtraction'(k));
      assign w_lanePop  = (r_count != '0) && w_popReady[k];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wrPtr <= '0;
          r_rdPtr <= '0;
          r_count <= '0;
        end else begin
          if (w_lanePush)
            r_wrPtr <= (r_wrPtr == c_ptrWidth'(fifoDepth - 1)) ? '0 : r_wrPtr + c_ptrWidth'(1);
          if (w_lanePop)
            r_rdPtr <= (r_rdPtr == c_ptrWidth'(fifoDepth - 1)) ? '0 : r_rdPtr + c_ptrWidth'(1);
          if (w_lanePush && !w_lanePop)
            r_count <= r_count + c_cntWidth'(1);
          else if (!w_lanePush && w_lanePop)
            r_count <= r_count - c_cntWidth'(1);
        end
      end

      // Storage is not reset; occupancy alone decides what is visible.
      always_ff @(posedge clk) begin
        if (w_lanePush)
          r_mem[r_wrPtr] <= type_in;
      end

      assign w_count[k] = r_count;
      assign w_valid[k] = (r_count != '0);
      assign w_head[k]  = r_mem[r_rdPtr];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_dispatchCount <= '0;
    else if (w_push)
      r_dispatchCount <= r_dispatchCount + 16'd1;
  end

  assign dispatch_count    = r_dispatchCount;
  assign stateType_valid_0 = w_valid[0];
  assign stateType_valid_1 = w_valid[1];
  assign stateType_valid_2 = w_valid[2];
  assign stateType_valid_3 = w_valid[3];
  assign stateType_valid_4 = w_valid[4];
  assign stateType_valid_5 = w_valid[5];
  assign stateType_valid_6 = w_valid[6];
  assign stateType_valid_7 = w_valid[7];
  assign stateType_0       = w_head[0];
  assign stateType_1       = w_head[1];
  assign stateType_2       = w_head[2];
  assign stateType_3       = w_head[3];
  assign stateType_4       = w_head[4];
  assign stateType_5       = w_head[5];
  assign stateType_6       = w_head[6];
  assign stateType_7       = w_head[7];

endmodule
`default_nettype wire

// File: tb/tb_type_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_type_dispatcher: queue-model bench for type_dispatcher             |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_type_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [44:0] type_in = '0;
  logic        type_in_valid = 1'b0;
  logic        type_in_ready;
  logic [7:0]  rdy = '0;
  logic        stv [8];
  logic [44:0] st  [8];
  logic [15:0] dispatch_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: one queue per lane, capacity 4, plus a modulo-65536 word counter.
  logic [44:0] mq [8][$];
  int          mcount = 0;

  type_dispatcher dut (
    .clk(clk), .reset(reset), .type_in(type_in), .type_in_valid(type_in_valid),
    .type_in_ready(type_in_ready),
    .stateType_valid_0(stv[0]), .stateType_valid_1(stv[1]), .stateType_valid_2(stv[2]),
    .stateType_valid_3(stv[3]), .stateType_valid_4(stv[4]), .stateType_valid_5(stv[5]),
    .stateType_valid_6(stv[6]), .stateType_valid_7(stv[7]),
    .stateType_0(st[0]), .stateType_1(st[1]), .stateType_2(st[2]), .stateType_3(st[3]),
    .stateType_4(st[4]), .stateType_5(st[5]), .stateType_6(st[6]), .stateType_7(st[7]),
    .stateType_ready_0(rdy[0]), .stateType_ready_1(rdy[1]), .stateType_ready_2(rdy[2]),
    .stateType_ready_3(rdy[3]), .stateType_ready_4(rdy[4]), .stateType_ready_5(rdy[5]),
    .stateType_ready_6(rdy[6]), .stateType_ready_7(rdy[7]),
    .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {ready, count, valids[7:0], heads masked by valid}
  function automatic logic [384:0] obs_vec();
    logic [384:0] v;
    v = '0;
    v[384]     = type_in_ready;
    v[383:368] = dispatch_count;
    for (int k = 0; k < 8; k++) begin
      v[360+k]    = stv[k];
      v[k*45 +: 45] = stv[k] ? st[k] : 45'd0;
    end
    return v;
  endfunction

  function automatic logic [384:0] exp_vec();
    logic [384:0] v;
    int s;
    v = '0;
    s = int'(type_in[44:42]);
    v[384]     = (mq[s].size() < 4);
    v[383:368] = 16'(mcount);
    for (int k = 0; k < 8; k++) begin
      v[360+k] = (mq[k].size() != 0);
      if (mq[k].size() != 0) v[k*45 +: 45] = mq[k][0];
    end
    return v;
  endfunction

  function automatic logic [44:0] rand_word(input int lane);
    logic [44:0] w;
    w = {$urandom, $urandom};
    w[44:42] = 3'(lane);
    return w;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mq[k].delete();
    mcount = 0;
  endtask

  task automatic drive(input logic v, input logic [44:0] d, input logic [7:0] r);
    type_in_valid = v;
    type_in       = d;
    rdy           = r;
    #1;
  endtask

  // Advance one clock edge and apply the same transfer to the model.
  task automatic tick();
    logic       push;
    logic [7:0] pop;
    int         s;
    s    = int'(type_in[44:42]);
    push = type_in_valid && (mq[s].size() < 4);
    for (int k = 0; k < 8; k++) pop[k] = rdy[k] && (mq[k].size() != 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) if (pop[k]) void'(mq[k].pop_front());
    if (push) begin
      mq[s].push_back(type_in);
      mcount = (mcount + 1) % 65536;
    end
  endtask

  task automatic test_reset();
    logic [384:0] o, e;
    reset = 1'b1;
    drive(1'b1, rand_word(3), 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", o, e); end
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, rand_word(s), 8'h00);
      n_tests++;
      if (type_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready lane %0d: got %b want 1", s, type_in_ready);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single_word();
    logic [44:0] w;
    logic [384:0] o, e;
    w = 45'h0A_0000_1234;
    w[44:42] = 3'd5;
    drive(1'b1, w, 8'hFF);
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL single_pre: got %h want %h", o, e); end
    tick();
    drive(1'b0, 45'd0, 8'hFF);
    n_tests++;
    if ({stv[5], st[5], dispatch_count} !== {1'b1, w, 16'd1}) begin
      n_fail++;
      $display("FAIL single_word: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=1", stv[5], st[5], dispatch_count, w);
    end
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL single_lanes: got %h want %h", o, e); end
    tick();
    n_tests++;
    if (stv[5] !== 1'b0) begin n_fail++; $display("FAIL single_once: got v5=%b want 0", stv[5]); end
  endtask

  task automatic test_full_lane();
    logic [44:0] w [5];
    logic [44:0] got [$];
    logic [384:0] o, e;
    logic         sent;
    for (int i = 0; i < 5; i++) w[i] = rand_word(2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], 8'hFB);
      o = obs_vec(); e = exp_vec(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL fill_%0d: got %h want %h", i, o, e); end
      tick();
    end
    drive(1'b1, w[4], 8'hFB);
    n_tests++;
    if (type_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", type_in_ready); end
    tick();
    // Another lane must not be blocked by the full lane 2.
    drive(1'b1, rand_word(6), 8'hFB);
    n_tests++;
    if (type_in_ready !== 1'b1) begin n_fail++; $display("FAIL hol_ready: got %b want 1", type_in_ready); end
    tick();
    drive(1'b0, w[4], 8'hFB);
    n_tests++;
    if (stv[6] !== 1'b1) begin n_fail++; $display("FAIL hol_valid6: got %b want 1", stv[6]); end
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL hol_state: got %h want %h", o, e); end
    sent = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(!sent, w[4], 8'hFF);
      o = obs_vec(); e = exp_vec(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", c, o, e); end
      if (stv[2]) got.push_back(st[2]);
      if (!sent && type_in_ready) sent = 1'b1;
      tick();
    end
    n_tests++;
    if (got.size() != 5) begin
      n_fail++; $display("FAIL drain_count: got %0d words want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (got[i] !== w[i]) begin n_fail++; $display("FAIL drain_order %0d: got %h want %h", i, got[i], w[i]); end
      end
    end
  endtask

  task automatic test_concurrent();
    logic [44:0] sent [$];
    logic [44:0] got [$];
    logic [44:0] w;
    logic [384:0] o, e;
    for (int i = 0; i < 2; i++) begin
      w = rand_word(0); sent.push_back(w);
      drive(1'b1, w, 8'hFE);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      w = rand_word(0); sent.push_back(w);
      drive(1'b1, w, 8'hFF);
      o = obs_vec(); e = exp_vec(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL pushpop_%0d: got %h want %h", i, o, e); end
      if (stv[0]) got.push_back(st[0]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 45'd0, 8'hFF);
      if (stv[0]) got.push_back(st[0]);
      tick();
    end
    n_tests++;
    if (got.size() != sent.size()) begin
      n_fail++; $display("FAIL pushpop_count: got %0d want %0d", got.size(), sent.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        n_tests++;
        if (got[i] !== sent[i]) begin n_fail++; $display("FAIL pushpop_order %0d: got %h want %h", i, got[i], sent[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [384:0] o, e;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rand_word((i % 2) ? 7 : 1), 8'h00);
      tick();
    end
    drive(1'b0, rand_word(1), 8'h00);
    reset = 1'b1;
    #1;
    model_clear();
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL midreset_async: got %h want %h", o, e); end
    n_tests++;
    if (dispatch_count !== 16'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", dispatch_count); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rand_word(7), 8'hFF);
      o = obs_vec(); e = exp_vec(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_stale_%0d: got %h want %h", i, o, e); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [384:0] o, e;
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, rand_word($urandom % 8), 8'($urandom & $urandom));
      o = obs_vec(); e = exp_vec(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (errs < 10) $display("FAIL random cycle %0d: got %h want %h", i, o, e);
        errs++;
      end
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    logic [384:0] o, e;
    drive(1'b0, 45'd0, 8'hFF);
    reset = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    drive(1'b1, rand_word(3), 8'hFF);
    for (int i = 1; i <= 65537; i++) begin
      tick();
      if (i == 65535) begin
        n_tests++;
        if (dispatch_count !== 16'hFFFF) begin n_fail++; $display("FAIL count_max: got %0d want 65535", dispatch_count); end
      end
    end
    drive(1'b0, 45'd0, 8'hFF);
    n_tests++;
    if (dispatch_count !== 16'd1) begin n_fail++; $display("FAIL count_wrap: got %0d want 1", dispatch_count); end
    o = obs_vec(); e = exp_vec(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL wrap_state: got %h want %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_lane();
    test_concurrent();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
